// File: rtl/pool_addr_sched.sv
// pool_addr_sched: address scheduler for a pooled transform.
// A go in IDLE loads the LFSR seed and the sample count, pulses start,
// waits INIT_CYC cycles, then in RUN walks four pool addresses (p/q/r/s
// spaced by 256) from a 10-bit LFSR base that advances every two cycles.
// c_valid follows RUN entry by PIPE_LAT cycles and counts samples until
// n_samples is reached (0 = unbounded). stop aborts to IDLE without done.
//
// Ports:
//   CK, RB              clock, async active-low reset
//   go, stop            run request (IDLE only), abort (stop wins over go)
//   seed, n_samples     LFSR seed and run length, sampled on accepted go
//   start               one-cycle pulse at run start
//   p/q/r/s_addr        pool addresses
//   c_valid             transform output holds a counted sample
//   busy, done          activity flag, end-of-bounded-run pulse
//   total_cnt           (only with POOL_ADDR_SCHED_CNT_EN) saturating count
//                       of c_valid cycles since reset
module pool_addr_sched #(
    parameter int unsigned PIPE_LAT = 6,
    parameter int unsigned INIT_CYC = 1025
) (
    input  logic        CK,
    input  logic        RB,
    input  logic        go,
    input  logic        stop,
    input  logic [9:0]  seed,
    input  logic [15:0] n_samples,
    output logic        start,
    output logic [9:0]  p_addr,
    output logic [9:0]  q_addr,
    output logic [9:0]  r_addr,
    output logic [9:0]  s_addr,
    output logic        c_valid,
    output logic        busy,
    output logic        done
`ifdef POOL_ADDR_SCHED_CNT_EN
    ,
    output logic [31:0] total_cnt
`endif
);

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned INIT_W = $clog2(INIT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_INIT  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_b;
    logic                r_phase;
    logic [INIT_W-1:0]   r_init_cnt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_nsamp;
    logic [PIPE_LAT-1:0] r_dl;
    logic                r_start;
    logic                r_busy;
    logic                r_done;

    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_cnt_hit;
    logic                w_init_last;
    logic [ADDR_W-1:0]   w_b_next;
    logic [ADDR_W-1:0]   w_seed_ld;

    assign w_b_next    = {r_b[8:0], r_b[9] ^ r_b[6]};
    assign w_seed_ld   = (seed == '0) ? ADDR_W'(1) : seed;
    assign w_init_last = (r_init_cnt == INIT_W'(INIT_CYC - 1));

    // Next-state logic; the count hit uses the incremented value so the
    // last sample's edge is also the RUN->DONE edge.
    always_comb begin
        w_next    = r_state;
        w_cnt_inc = r_cnt + CNT_W'(1);
        w_cnt_hit = c_valid && (r_nsamp != '0) && (w_cnt_inc == r_nsamp);
        case (r_state)
            S_IDLE:  if (go && !stop) w_next = S_START;
            S_START: w_next = stop ? S_IDLE : S_INIT;
            S_INIT: begin
                if (stop)             w_next = S_IDLE;
                else if (w_init_last) w_next = S_RUN;
            end
            S_RUN: begin
                if (stop)           w_next = S_IDLE;
                else if (w_cnt_hit) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == S_START);
            r_busy  <= (w_next == S_START) || (w_next == S_INIT) || (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
        end
    end

    // LFSR base, pair phase, INIT timer, sample counter.
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_b        <= ADDR_W'(1);
            r_phase    <= 1'b0;
            r_init_cnt <= '0;
            r_cnt      <= '0;
            r_nsamp    <= '0;
        end else begin
            if (r_state == S_IDLE && w_next == S_START) begin
                r_b     <= w_seed_ld;
                r_nsamp <= n_samples;
                r_cnt   <= '0;
            end else begin
                if (r_state == S_RUN && w_next == S_RUN && r_phase) r_b <= w_b_next;
                if (r_state == S_RUN && c_valid) r_cnt <= w_cnt_inc;
            end
            r_phase    <= (r_state == S_RUN && w_next == S_RUN) ? ~r_phase : 1'b0;
            r_init_cnt <= (r_state == S_INIT) ? r_init_cnt + INIT_W'(1) : '0;
        end
    end

    // Run-tracking delay line; flushed whenever RUN is left so c_valid
    // drops on the same edge.
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_dl <= '0;
        end else if (w_next != S_RUN) begin
            r_dl <= '0;
        end else begin
            r_dl <= (r_dl << 1) | PIPE_LAT'(r_state == S_RUN);
        end
    end

    assign start   = r_start;
    assign busy    = r_busy;
    assign done    = r_done;
    assign c_valid = r_dl[PIPE_LAT-1];
    assign p_addr  = r_b;
    assign q_addr  = r_b + 10'd256;
    assign r_addr  = r_b + 10'd512;
    assign s_addr  = r_b + 10'd768;

`ifdef POOL_ADDR_SCHED_CNT_EN
    logic [31:0] r_total;

    // Lifetime sample count, saturating, cleared only by reset.
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_total <= '0;
        end else if (c_valid && (r_total != '1)) begin
            r_total <= r_total + 32'd1;
        end
    end

    assign total_cnt = r_total;
`endif

endmodule

// File: tb/tb_pool_addr_sched.sv
// Directed bench for pool_addr_sched with an address scoreboard: each RUN
// cycle that should yield a sample pushes its base address; each c_valid
// pops one and compares it with p_addr from PIPE_LAT cycles earlier.
module tb_pool_addr_sched;

    localparam int PL = 6;
    localparam int IC = 1025;

    logic        CK = 1'b0;
    logic        RB;
    logic        go;
    logic        stop;
    logic [9:0]  seed;
    logic [15:0] n_samples;
    logic        start;
    logic [9:0]  p_addr;
    logic [9:0]  q_addr;
    logic [9:0]  r_addr;
    logic [9:0]  s_addr;
    logic        c_valid;
    logic        busy;
    logic        done;
`ifdef POOL_ADDR_SCHED_CNT_EN
    logic [31:0] total_cnt;
`endif

    pool_addr_sched #(.PIPE_LAT(PL), .INIT_CYC(IC)) dut (
        .CK        (CK),
        .RB        (RB),
        .go        (go),
        .stop      (stop),
        .seed      (seed),
        .n_samples (n_samples),
        .start     (start),
        .p_addr    (p_addr),
        .q_addr    (q_addr),
        .r_addr    (r_addr),
        .s_addr    (s_addr),
        .c_valid   (c_valid),
        .busy      (busy),
        .done      (done)
`ifdef POOL_ADDR_SCHED_CNT_EN
        ,
        .total_cnt (total_cnt)
`endif
    );

    always #5 CK = ~CK;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cv_run   = 0;
    int         done_cnt = 0;
    int         tot_model = 0;
    int         d0;
    logic [9:0] sb[$];
    logic [9:0] p_log[$];
    logic [9:0] hist[PL+1];

    function automatic logic [9:0] lfsr(input logic [9:0] b);
        return {b[8:0], b[9] ^ b[6]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 time unit after the edge.
    task automatic step();
        @(posedge CK);
        #1;
        for (int i = PL; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = p_addr;
        if (c_valid === 1'b1) begin
            cv_run++;
            if (sb.size() == 0) check("cv_unexpected", 32'(c_valid), 32'(0));
            else check("cv_addr", 32'(hist[PL]), 32'(sb.pop_front()));
        end
        if (done === 1'b1) done_cnt++;
    endtask

    // Issue go, check the start pulse, and stop on the last INIT cycle.
    task automatic start_run(input logic [9:0] sd, input logic [15:0] n, input bit inject_go);
        logic [9:0] b0;
        b0 = (sd == 10'd0) ? 10'h001 : sd;
        seed = sd;
        n_samples = n;
        go = 1'b1;
        step();
        go = 1'b0;
        seed = ~sd;
        n_samples = n + 16'd3;
        check("start_pulse", 32'(start), 32'(1));
        check("busy_start", 32'(busy), 32'(1));
        step();
        check("start_one_cycle", 32'(start), 32'(0));
        if (inject_go) begin
            go = 1'b1;
            step();
            go = 1'b0;
            check("init_go_ignored", 32'(start), 32'(0));
            repeat (IC - 2) step();
        end else begin
            repeat (IC - 1) step();
        end
        check("init_hold_p", 32'(p_addr), 32'(b0));
        check("init_cv", 32'(c_valid), 32'(0));
        check("init_busy", 32'(busy), 32'(1));
        cv_run = 0;
        p_log.delete();
    endtask

    // Walk RUN cycles against the address model; n_push < 0 = unbounded.
    task automatic run_phase(input logic [9:0] b0, input int n_push, input int ncyc);
        logic [9:0] mb;
        logic [9:0] eq;
        logic [9:0] er;
        logic [9:0] es;
        int pushed;
        mb = b0;
        pushed = 0;
        for (int k = 0; k < ncyc; k++) begin
            step();
            p_log.push_back(p_addr);
            eq = mb + 10'd256;
            er = mb + 10'd512;
            es = mb + 10'd768;
            check("p_addr", 32'(p_addr), 32'(mb));
            check("q_addr", 32'(q_addr), 32'(eq));
            check("r_addr", 32'(r_addr), 32'(er));
            check("s_addr", 32'(s_addr), 32'(es));
            if (k == PL - 1) check("cv_before_lat", 32'(c_valid), 32'(0));
            if (k == PL && n_push != 0) check("cv_at_lat", 32'(c_valid), 32'(1));
            if (n_push < 0 || pushed < n_push) begin
                sb.push_back(mb);
                pushed++;
            end
            if (k % 2 == 1) mb = lfsr(mb);
        end
    endtask

    task automatic finish_bounded(input int n);
        step();
        check("done_pulse", 32'(done), 32'(1));
        check("busy_done", 32'(busy), 32'(0));
        check("cv_done", 32'(c_valid), 32'(0));
        step();
        check("done_one_cycle", 32'(done), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
        check("sample_count", 32'(cv_run), 32'(n));
        check("sb_empty", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RB = 1'b0;
        go = 1'b0;
        stop = 1'b0;
        seed = 10'd0;
        n_samples = 16'd0;
        for (int i = 0; i <= PL; i++) hist[i] = 10'd0;
        repeat (2) @(posedge CK);
        #1;
        check("rst_start", 32'(start), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_cv", 32'(c_valid), 32'(0));
        check("rst_p", 32'(p_addr), 32'(10'h001));
        check("rst_s", 32'(s_addr), 32'(10'h301));
        RB = 1'b1;
        step();

        // Seed 0 -> base 001, bounded run of 4 samples.
        d0 = done_cnt;
        start_run(10'd0, 16'd4, 1'b0);
        run_phase(10'h001, 4, 10);
        check("t1_p0", 32'(p_log[0]), 32'(10'h001));
        check("t1_p2", 32'(p_log[2]), 32'(10'h002));
        finish_bounded(4);
        check("t1_one_done", 32'(done_cnt - d0), 32'(1));

        // Unbounded run from seed 040, then stop.
        start_run(10'h040, 16'd0, 1'b0);
        run_phase(10'h040, -1, 20);
        check("t2_p1", 32'(p_log[1]), 32'(10'h040));
        check("t2_p2", 32'(p_log[2]), 32'(10'h081));
        check("t2_p4", 32'(p_log[4]), 32'(10'h102));
        check("t2_cv_continuous", 32'(cv_run), 32'(14));
        d0 = done_cnt;
        stop = 1'b1;
        step();
        stop = 1'b0;
        sb.delete();
        check("t2_stop_busy", 32'(busy), 32'(0));
        check("t2_stop_cv", 32'(c_valid), 32'(0));
        repeat (3) step();
        check("t2_no_done", 32'(done_cnt - d0), 32'(0));

        // go during INIT ignored; go+stop together in RUN -> stop wins.
        start_run(10'h005, 16'd0, 1'b1);
        run_phase(10'h005, -1, 8);
        d0 = done_cnt;
        go = 1'b1;
        stop = 1'b1;
        step();
        go = 1'b0;
        stop = 1'b0;
        sb.delete();
        check("t3_busy", 32'(busy), 32'(0));
        check("t3_start", 32'(start), 32'(0));
        check("t3_cv", 32'(c_valid), 32'(0));
        step();
        check("t3_still_idle", 32'(busy), 32'(0));
        check("t3_no_done", 32'(done_cnt - d0), 32'(0));

        // Reset mid-RUN after 3 samples, then a fresh 2-sample run.
        start_run(10'h123, 16'd10, 1'b0);
        run_phase(10'h123, 10, 9);
        check("t4_three_samples", 32'(cv_run), 32'(3));
        d0 = done_cnt;
        #2;
        RB = 1'b0;
        #1;
        check("t4_rst_cv", 32'(c_valid), 32'(0));
        check("t4_rst_busy", 32'(busy), 32'(0));
        check("t4_rst_start", 32'(start), 32'(0));
        check("t4_rst_done", 32'(done), 32'(0));
        check("t4_rst_p", 32'(p_addr), 32'(10'h001));
        check("t4_rst_q", 32'(q_addr), 32'(10'h101));
        sb.delete();
        tot_model = 0;
`ifdef POOL_ADDR_SCHED_CNT_EN
        check("t4_rst_total", total_cnt, 32'd0);
`endif
        @(posedge CK);
        #1;
        RB = 1'b1;
        repeat (3) step();
        check("t4_needs_go", 32'(busy), 32'(0));
        check("t4_no_done", 32'(done_cnt - d0), 32'(0));
        start_run(10'h002, 16'd2, 1'b0);
        run_phase(10'h002, 2, 8);
        finish_bounded(2);
        tot_model += 2;

        // Two runs of 5 samples for the lifetime counter.
        start_run(10'h3FF, 16'd5, 1'b0);
        run_phase(10'h3FF, 5, 11);
        finish_bounded(5);
        tot_model += 5;
        start_run(10'h155, 16'd5, 1'b0);
        run_phase(10'h155, 5, 11);
        finish_bounded(5);
        tot_model += 5;
`ifdef POOL_ADDR_SCHED_CNT_EN
        check("total_cnt", total_cnt, 32'(tot_model));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
